// File: rtl/issue_ctrl.sv
// ---------------------------------------------------------------------------
// issue_ctrl
//   Consumer end of the decode/issue buffer. Looks at the two oldest buffer
//   entries (slot A = oldest, slot B = next) and decides each cycle whether
//   0, 1 or 2 instructions issue. The pop count goes back to the buffer.
//   A per-register load-use scoreboard holds off consumers of recent loads.
//   The issue valids toward EX are registered, and two performance counters
//   are kept.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   is_valid[1:0]       head valids, [1]=slot A, [0]=slot B
//   a_*/b_*             per-slot sources, destination, write enable and
//                       class flags (load, mem, branch, solo)
//   stall               DCache / divider stall (freezes issue and state)
//   flush               branch-mispredict flush (kills issue this cycle)
//   using_num[1:0]      combinational pop count: 0, 1 or 2
//   ex_valid[1:0]       registered issue valids to EX, [1]=A, [0]=B
//   perf_issued         running count of issued instructions
//   perf_dual           running count of dual-issue cycles
// ---------------------------------------------------------------------------
module issue_ctrl #(
  parameter int NREG     = 32,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 2,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        is_valid,
  input  logic [4:0]        a_raddr1,
  input  logic [4:0]        a_raddr2,
  input  logic [4:0]        a_rd,
  input  logic              a_we,
  input  logic              a_is_load,
  input  logic              a_is_mem,
  input  logic              a_is_br,
  input  logic              a_is_solo,
  input  logic [4:0]        b_raddr1,
  input  logic [4:0]        b_raddr2,
  input  logic [4:0]        b_rd,
  input  logic              b_we,
  input  logic              b_is_load,
  input  logic              b_is_mem,
  input  logic              b_is_br,
  input  logic              b_is_solo,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        using_num,
  output logic [1:0]        ex_valid,
  output logic [PERF_W-1:0] perf_issued,
  output logic [PERF_W-1:0] perf_dual
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(LOAD_LAT);

  logic [CNT_W-1:0] r_cnt [NREG];
  logic [NREG-1:0]  w_busy;
  logic             w_issue_a;
  logic             w_issue_b;
  logic             w_raw_ab;
  logic             w_set_a;
  logic             w_set_b;

  // r0 is hardwired, so its entry is never reported busy.
  always_comb begin
    w_busy = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      w_busy[i] = (r_cnt[i] != '0);
    end
  end

  // Slot B may not read or overwrite what slot A writes in the same cycle.
  assign w_raw_ab = a_we && (a_rd != 5'd0) &&
                    ((b_raddr1 == a_rd) || (b_raddr2 == a_rd) ||
                     (b_we && (b_rd == a_rd)));

  // is_valid == 2'b01 never issues because slot B depends on slot A issuing.
  assign w_issue_a = is_valid[1] && !stall && !flush &&
                     !w_busy[a_raddr1] && !w_busy[a_raddr2];

  assign w_issue_b = w_issue_a && is_valid[0] &&
                     !a_is_solo && !b_is_solo &&
                     !w_busy[b_raddr1] && !w_busy[b_raddr2] &&
                     !w_raw_ab &&
                     !(a_is_mem && b_is_mem) &&
                     !(a_is_br && b_is_br);

  assign using_num = w_issue_b ? 2'd2 : (w_issue_a ? 2'd1 : 2'd0);

  assign w_set_a = w_issue_a && a_is_load && a_we && (a_rd != 5'd0);
  assign w_set_b = w_issue_b && b_is_load && b_we && (b_rd != 5'd0);

  // Counters keep running through a flush: older loads still write back.
  // A new load's set wins over the decrement of the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (!stall) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if ((w_set_a && (a_rd == 5'(i))) || (w_set_b && (b_rd == 5'(i)))) begin
          r_cnt[i] <= LAT;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  // Flush takes priority over stall on the EX valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 2'b00;
    end else if (flush) begin
      ex_valid <= 2'b00;
    end else if (!stall) begin
      ex_valid <= {w_issue_a, w_issue_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= '0;
      perf_dual   <= '0;
    end else if (!stall && !flush) begin
      perf_issued <= perf_issued + PERF_W'(using_num);
      perf_dual   <= perf_dual + PERF_W'(w_issue_b);
    end
  end

endmodule
